// File: rtl/rename_pkg.sv
// Shared rename-stage constants, tag/count types and the freelist rebuild state encoding.
package rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHY_REGS  = 64;
    localparam int PHY_WIDTH = 6;
    localparam int FREE_REG  = PHY_REGS - ARCH_REGS;
    localparam int CNT_WIDTH = PHY_WIDTH + 1;

    typedef logic [PHY_WIDTH-1:0] phy_tag_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WALK  = 2'd2
    } fl_state_e;

    // Architectural registers start out mapped one-to-one onto the low physical tags.
    localparam logic [PHY_REGS-1:0] LIVE_RESET = {{(PHY_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/freelist_rebuild_walker.sv
// Flush-time rebuild sequencer: clears the freelist, then scans every physical tag
// and re-pushes the ones that are not committed-live.
module freelist_rebuild_walker
    import rename_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [PHY_REGS-1:0] live,
    output fl_state_e           state,
    output logic                fl_clear,
    output logic                walk_push_valid,
    output phy_tag_t            walk_push_phy
);

    fl_state_e state_r;
    fl_state_e state_next_s;
    phy_tag_t  idx_r;
    phy_tag_t  idx_next_s;

    // State and scan-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= phy_tag_t'(0);
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state, index advance and push generation; a flush during rebuild restarts it
    // and drops the current scan push since the freelist is about to be cleared.
    always_comb begin
        state_next_s    = state_r;
        idx_next_s      = idx_r;
        fl_clear        = 1'b0;
        walk_push_valid = 1'b0;
        walk_push_phy   = phy_tag_t'(0);
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                fl_clear   = 1'b1;
                idx_next_s = phy_tag_t'(0);
                if (flush) begin
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = WALK;
                end
            end
            WALK: begin
                if (flush) begin
                    state_next_s = CLEAR;
                end else begin
                    if (!live[idx_r]) begin
                        walk_push_valid = 1'b1;
                        walk_push_phy   = idx_r;
                    end else begin
                        walk_push_valid = 1'b0;
                    end
                    idx_next_s = idx_r + phy_tag_t'(1);
                    if (idx_r == phy_tag_t'(PHY_REGS-1)) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = WALK;
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign state = state_r;

endmodule

// File: rtl/freelist_alloc_ctrl.sv
// Rename-stage freelist controller: 2-wide all-or-nothing allocation, retire-driven
// frees, committed-live bitmap and flush rebuild via freelist_rebuild_walker.
module freelist_alloc_ctrl
    import rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           rename_req,
    input  logic [PHY_WIDTH-1:0] fl_head_0,
    input  logic [PHY_WIDTH-1:0] fl_head_1,
    output logic [1:0]           rename_grant,
    output logic                 rename_stall,
    output logic [PHY_WIDTH-1:0] alloc_phy_0,
    output logic [PHY_WIDTH-1:0] alloc_phy_1,
    output logic [1:0]           fl_pop,
    input  logic                 retire_valid,
    input  logic [PHY_WIDTH-1:0] retire_phy_old,
    input  logic [PHY_WIDTH-1:0] retire_phy_new,
    output logic                 fl_push_valid,
    output logic [PHY_WIDTH-1:0] fl_push_phy,
    output logic                 fl_clear,
    output logic                 rebuild_busy,
    output logic [PHY_WIDTH:0]   num_free
);

    fl_state_e           state_s;
    logic                walk_push_valid_s;
    phy_tag_t            walk_push_phy_s;
    logic [PHY_REGS-1:0] live_r;
    logic [PHY_REGS-1:0] live_next_s;
    cnt_t                num_free_r;
    logic [1:0]          need_s;
    logic                grant_ok_s;
    logic                retire_push_s;
    logic                retire_upd_s;

    freelist_rebuild_walker u_walker (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .live            (live_r),
        .state           (state_s),
        .fl_clear        (fl_clear),
        .walk_push_valid (walk_push_valid_s),
        .walk_push_phy   (walk_push_phy_s)
    );

    assign need_s     = popcount2(rename_req);
    assign grant_ok_s = (state_s == IDLE) && !flush && (cnt_t'(need_s) <= num_free_r);

    // Grant and tag steering; a single requesting slot always takes the head entry.
    always_comb begin
        rename_grant = 2'b00;
        fl_pop       = 2'b00;
        alloc_phy_0  = phy_tag_t'(0);
        alloc_phy_1  = phy_tag_t'(0);
        if (grant_ok_s) begin
            rename_grant = rename_req;
            fl_pop       = need_s;
            case (rename_req)
                2'b11: begin
                    alloc_phy_0 = fl_head_0;
                    alloc_phy_1 = fl_head_1;
                end
                2'b10:   alloc_phy_1 = fl_head_0;
                2'b01:   alloc_phy_0 = fl_head_0;
                default: alloc_phy_0 = phy_tag_t'(0);
            endcase
        end else begin
            rename_grant = 2'b00;
            fl_pop       = 2'b00;
        end
    end

    assign rename_stall = (rename_req != 2'b00) && (rename_grant == 2'b00);

    // Tag 0 is permanently live, so freeing it is dropped; the flush cycle's freelist gets cleared.
    assign retire_push_s = retire_valid && (state_s == IDLE) && !flush &&
                           (retire_phy_old != phy_tag_t'(0));
    assign retire_upd_s  = retire_valid && ((state_s == IDLE) || flush);

    // Freelist push mux: retire frees in IDLE, scan pushes during WALK, never both.
    always_comb begin
        fl_push_valid = retire_push_s | walk_push_valid_s;
        if (retire_push_s) begin
            fl_push_phy = retire_phy_old;
        end else begin
            fl_push_phy = walk_push_phy_s;
        end
    end

    // Live bitmap next value: free old mapping, then mark new one (new wins on alias).
    always_comb begin
        live_next_s = live_r;
        if (retire_upd_s) begin
            live_next_s[retire_phy_old] = 1'b0;
            live_next_s[retire_phy_new] = 1'b1;
        end else begin
            live_next_s = live_r;
        end
        live_next_s[0] = 1'b1;
    end

    // Live bitmap and free-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_r     <= LIVE_RESET;
            num_free_r <= cnt_t'(FREE_REG);
        end else begin
            live_r <= live_next_s;
            if (state_s == CLEAR) begin
                num_free_r <= cnt_t'(0);
            end else begin
                num_free_r <= num_free_r - cnt_t'(fl_pop) + cnt_t'(fl_push_valid);
            end
        end
    end

    assign rebuild_busy = (state_s != IDLE);
    assign num_free     = num_free_r;

endmodule
